// File: rtl/risk_issue.sv
// Command FIFO and issue sequencer for the risk matrix unit: queues commands from the
// scalar core and drives each one onto the risk_* ports for its per-function hold time.
module risk_issue #(
    parameter int DEPTH        = 4,
    parameter int LOAD_CYCLES  = 2,
    parameter int STORE_CYCLES = 2,
    parameter int OP_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_func,
    input  logic [4:0]  cmd_reg,
    input  logic [14:0] cmd_addr,
    input  logic [13:0] cmd_stride_x,
    input  logic [13:0] cmd_stride_y,
    output logic [2:0]  risk_func,
    output logic [4:0]  risk_reg,
    output logic [14:0] risk_addr,
    output logic [13:0] risk_stride_x,
    output logic [13:0] risk_stride_y,
    output logic        busy,
    output logic        idle,
    output logic [15:0] issued_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int MAX_LS = (LOAD_CYCLES > STORE_CYCLES) ? LOAD_CYCLES : STORE_CYCLES;
    localparam int MAX_H  = (MAX_LS > OP_CYCLES) ? MAX_LS : OP_CYCLES;
    localparam int HOLD_W = (MAX_H > 1) ? $clog2(MAX_H) : 1;

    typedef struct packed {
        logic [2:0]  func;
        logic [4:0]  rreg;
        logic [14:0] addr;
        logic [13:0] sx;
        logic [13:0] sy;
    } entry_t;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    // Hold counter loads H-1 so that a value of zero marks the last cycle of a command.
    function automatic logic [HOLD_W-1:0] hold_len_m1(input logic [2:0] func);
        case (func)
            3'b000:  return '0;
            3'b001:  return HOLD_W'(STORE_CYCLES - 1);
            3'b010:  return HOLD_W'(LOAD_CYCLES - 1);
            default: return HOLD_W'(OP_CYCLES - 1);
        endcase
    endfunction

    entry_t             mem_q [DEPTH];
    entry_t             out_q, out_d, head, cmd_entry;
    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        issued_q, issued_d;
    logic               push, pop;

    assign cmd_entry = '{func: cmd_func, rreg: cmd_reg, addr: cmd_addr,
                         sx: cmd_stride_x, sy: cmd_stride_y};
    assign head      = mem_q[rd_ptr_q];
    // No pass-through when full: a pop on the same edge does not open the queue.
    assign cmd_ready = (count_q < CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        out_d    = out_q;
        issued_d = issued_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) pop = 1'b1;
            end
            S_HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (count_q != '0) begin
                    pop = 1'b1;
                end else begin
                    out_d.func = 3'b000;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            out_d    = head;
            hold_d   = hold_len_m1(head.func);
            issued_d = issued_q + 16'd1;
            state_d  = S_HOLD;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            out_q    <= '0;
            issued_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            out_q    <= out_d;
            issued_q <= issued_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage holds data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_entry;
    end

    assign risk_func     = out_q.func;
    assign risk_reg      = out_q.rreg;
    assign risk_addr     = out_q.addr;
    assign risk_stride_x = out_q.sx;
    assign risk_stride_y = out_q.sy;
    assign busy          = (state_q == S_HOLD);
    assign idle          = (count_q == '0) && (state_q != S_HOLD);
    assign issued_count  = issued_q;

endmodule

// File: tb/tb_risk_issue.sv
// Directed bench for risk_issue: a default-parameter instance plus a slow-load instance
// (LOAD_CYCLES=4) used to back the queue up and to interrupt a load with reset.
module tb_risk_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_valid_s;
    logic [2:0]  cmd_func;
    logic [4:0]  cmd_reg;
    logic [14:0] cmd_addr;
    logic [13:0] cmd_stride_x, cmd_stride_y;

    logic        cmd_ready, busy, idle;
    logic [2:0]  risk_func;
    logic [4:0]  risk_reg;
    logic [14:0] risk_addr;
    logic [13:0] risk_sx, risk_sy;
    logic [15:0] issued;

    logic        cmd_ready_s, busy_s, idle_s;
    logic [2:0]  risk_func_s;
    logic [4:0]  risk_reg_s;
    logic [14:0] risk_addr_s;
    logic [13:0] risk_sx_s, risk_sy_s;
    logic [15:0] issued_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    risk_issue u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_func(cmd_func), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
        .risk_func(risk_func), .risk_reg(risk_reg), .risk_addr(risk_addr),
        .risk_stride_x(risk_sx), .risk_stride_y(risk_sy),
        .busy(busy), .idle(idle), .issued_count(issued)
    );

    risk_issue #(.DEPTH(4), .LOAD_CYCLES(4), .STORE_CYCLES(2), .OP_CYCLES(1)) u_slow (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
        .cmd_func(cmd_func), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
        .risk_func(risk_func_s), .risk_reg(risk_reg_s), .risk_addr(risk_addr_s),
        .risk_stride_x(risk_sx_s), .risk_stride_y(risk_sy_s),
        .busy(busy_s), .idle(idle_s), .issued_count(issued_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [2:0] f, input logic [4:0] r, input logic [14:0] a,
                           input logic [13:0] sx, input logic [13:0] sy);
        cmd_func = f; cmd_reg = r; cmd_addr = a; cmd_stride_x = sx; cmd_stride_y = sy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rdy;
        int         k;
        int         last;
        logic [0:6] ready_exp;

        reset = 1'b1; cmd_valid = 1'b0; cmd_valid_s = 1'b0;
        set_cmd(3'b000, 5'd0, 15'd0, 14'd0, 14'd0);
        tick; tick;

        // Reset state
        check("rst_func",   32'(risk_func), 32'd0);
        check("rst_reg",    32'(risk_reg),  32'd0);
        check("rst_addr",   32'(risk_addr), 32'd0);
        check("rst_sx",     32'(risk_sx),   32'd0);
        check("rst_sy",     32'(risk_sy),   32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_idle",   32'(idle),      32'd1);
        check("rst_ready",  32'(cmd_ready), 32'd1);
        check("rst_issued", 32'(issued),    32'd0);
        reset = 1'b0;
        tick;

        // Single load: 2 hold cycles, then NOP with fields kept
        set_cmd(3'b010, 5'd0, 15'd0, 14'd1, 14'd4);
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        check("ld_lat_func", 32'(risk_func), 32'd0);
        check("ld_lat_idle", 32'(idle),      32'd0);
        tick;
        check("ld_c1_func",   32'(risk_func), 32'd2);
        check("ld_c1_addr",   32'(risk_addr), 32'd0);
        check("ld_c1_sx",     32'(risk_sx),   32'd1);
        check("ld_c1_sy",     32'(risk_sy),   32'd4);
        check("ld_c1_busy",   32'(busy),      32'd1);
        check("ld_c1_issued", 32'(issued),    32'd1);
        tick;
        check("ld_c2_func", 32'(risk_func), 32'd2);
        check("ld_c2_sy",   32'(risk_sy),   32'd4);
        tick;
        check("ld_end_func",   32'(risk_func), 32'd0);
        check("ld_end_busy",   32'(busy),      32'd0);
        check("ld_end_idle",   32'(idle),      32'd1);
        check("ld_end_sx",     32'(risk_sx),   32'd1);
        check("ld_end_issued", 32'(issued),    32'd1);

        // Load then store pushed back-to-back: 010,010,001,001,000
        set_cmd(3'b010, 5'd1, 15'd5, 14'd2, 14'd3);
        cmd_valid = 1'b1;
        tick;
        set_cmd(3'b001, 5'd2, 15'd16, 14'd7, 14'd8);
        tick;
        cmd_valid = 1'b0;
        check("ls_1_func", 32'(risk_func), 32'd2);
        check("ls_1_addr", 32'(risk_addr), 32'd5);
        check("ls_1_reg",  32'(risk_reg),  32'd1);
        tick;
        check("ls_2_func", 32'(risk_func), 32'd2);
        tick;
        check("ls_3_func", 32'(risk_func), 32'd1);
        check("ls_3_addr", 32'(risk_addr), 32'd16);
        check("ls_3_reg",  32'(risk_reg),  32'd2);
        check("ls_3_sx",   32'(risk_sx),   32'd7);
        tick;
        check("ls_4_func", 32'(risk_func), 32'd1);
        tick;
        check("ls_5_func",   32'(risk_func), 32'd0);
        check("ls_5_issued", 32'(issued),    32'd3);
        check("ls_5_idle",   32'(idle),      32'd1);

        // Stream of 10 ops, addr 0..9 (pointer wrap); entry 5 is a queued NOP
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            cmd_valid = (k < 10);
            set_cmd((k == 5) ? 3'b000 : 3'b011, 5'(k), 15'(k), 14'd0, 14'd0);
            rdy = cmd_ready;
            tick;
            if (cmd_valid && rdy) k++;
            if (c >= 2 && c <= 11) begin
                check("st_addr", 32'(risk_addr), 32'(c - 2));
                check("st_func", 32'(risk_func), (c - 2 == 5) ? 32'd0 : 32'd3);
                check("st_busy", 32'(busy),      32'd1);
            end
        end
        cmd_valid = 1'b0;
        check("st_end_func",   32'(risk_func), 32'd0);
        check("st_end_idle",   32'(idle),      32'd1);
        check("st_end_issued", 32'(issued),    32'd13);

        // Slow instance: 4-cycle loads back the queue up until cmd_ready drops
        ready_exp = 7'b1111010;
        set_cmd(3'b010, 5'd3, 15'd200, 14'd0, 14'd0);
        k = 0;
        for (int c = 1; c <= 7; c++) begin
            cmd_valid_s = (k < 6);
            cmd_addr    = 15'(200 + k);
            rdy = cmd_ready_s;
            tick;
            if (cmd_valid_s && rdy) k++;
            check("fl_ready", 32'(cmd_ready_s), 32'(ready_exp[c-1]));
            if (c == 2) check("fl_addr_first", 32'(risk_addr_s), 32'd200);
            if (c == 6) check("fl_addr_next",  32'(risk_addr_s), 32'd201);
        end
        cmd_valid_s = 1'b0;
        last = int'(issued_s);
        for (int c = 0; c < 40 && !idle_s; c++) begin
            tick;
            if (int'(issued_s) != last) begin
                last = int'(issued_s);
                check("fl_order", 32'(risk_addr_s), 32'(200 + last - 1));
            end
        end
        check("fl_issued", 32'(issued_s),    32'd6);
        check("fl_idle",   32'(idle_s),      32'd1);
        check("fl_func",   32'(risk_func_s), 32'd0);

        // Reset in the middle of a load with 3 commands still queued
        set_cmd(3'b010, 5'd9, 15'd300, 14'd11, 14'd12);
        cmd_valid_s = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cmd_addr = 15'(300 + c);
            tick;
        end
        cmd_valid_s = 1'b0;
        check("rm_pre_busy", 32'(busy_s),      32'd1);
        check("rm_pre_addr", 32'(risk_addr_s), 32'd300);
        check("rm_pre_full", 32'(idle_s),      32'd0);
        #1 reset = 1'b1;
        #1;
        check("rm_func",   32'(risk_func_s), 32'd0);
        check("rm_addr",   32'(risk_addr_s), 32'd0);
        check("rm_reg",    32'(risk_reg_s),  32'd0);
        check("rm_sx",     32'(risk_sx_s),   32'd0);
        check("rm_sy",     32'(risk_sy_s),   32'd0);
        check("rm_busy",   32'(busy_s),      32'd0);
        check("rm_issued", 32'(issued_s),    32'd0);
        check("rm_ready",  32'(cmd_ready_s), 32'd1);
        check("rm_main_issued", 32'(issued), 32'd0);
        tick; tick;
        reset = 1'b0;
        tick; tick; tick;
        check("rm_post_idle",   32'(idle_s),      32'd1);
        check("rm_post_func",   32'(risk_func_s), 32'd0);
        check("rm_post_issued", 32'(issued_s),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
